// File: rtl/pn_stack_eval.sv
// pn_stack_eval
// Polish-notation expression evaluator. Tokens of one expression arrive on
// contiguous in_valid cycles and are buffered (up to MAX_TOK). Once in_valid
// drops, the buffer is walked one token per cycle against an operand stack of
// STK_DEPTH words: prefix frames are walked from the last token to the first,
// postfix frames from the first to the last.
//
// Build option: define PN_SAT_EN to clamp the results of opcodes 0-3 to the
// signed DW-bit range. Without it those results wrap modulo 2^DW.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          token strobe
//   mode              0 = prefix, 1 = postfix (taken from the first token)
//   operator          1 = token is an opcode, 0 = operand
//   in [OPW]          operand value or opcode
//   busy              frame in progress (through the out_valid cycle)
//   out_valid         one-cycle result strobe
//   out [DW] signed   result, 0 unless out_valid
//   err [2]           0 ok, 1 underflow, 2 overflow / bad final depth,
//                     3 token overflow; 0 unless out_valid
module pn_stack_eval #(
    parameter int DW        = 32,
    parameter int OPW       = 3,
    parameter int MAX_TOK   = 16,
    parameter int STK_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 mode,
    input  logic                 operator,
    input  logic [OPW-1:0]       in,
    output logic                 busy,
    output logic                 out_valid,
    output logic signed [DW-1:0] out,
    output logic [1:0]           err
);
    localparam int CNW = $clog2(MAX_TOK + 1);
    localparam int PW  = $clog2(MAX_TOK);
    localparam int DPW = $clog2(STK_DEPTH + 1);
    localparam int SIW = $clog2(STK_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, EVAL, DONE} state_t;

    state_t                state;
    logic [MAX_TOK-1:0]    tok_op;
    logic [OPW-1:0]        tok_val [MAX_TOK];
    logic [CNW-1:0]        cnt;
    logic [CNW-1:0]        step;
    logic [PW-1:0]         ptr;
    logic [DPW-1:0]        dep;
    logic                  mode_q;
    logic                  tok_ovf;
    logic signed [DW-1:0]  stk [STK_DEPTH];

    // ---------------- token buffer ----------------
    // In IDLE cnt is 0, so the first token lands in slot 0.
    logic tok_wr;
    assign tok_wr = in_valid &&
                    (state == IDLE || (state == RECV && cnt != CNW'(MAX_TOK)));

    always_ff @(posedge clk) begin
        if (tok_wr) begin
            tok_op[PW'(cnt)]  <= operator;
            tok_val[PW'(cnt)] <= in;
        end
    end

    // ---------------- evaluation step ----------------
    // The RECV cycle that sees in_valid low already evaluates the first
    // token, using the cleared pointer/depth/step values. This keeps EVAL
    // work in cycles k .. k+N-1 so the result registers in cycle k+N.
    logic            first;
    logic            eval_go;
    logic [PW-1:0]   cur_ptr;
    logic [DPW-1:0]  cur_dep;
    logic [CNW-1:0]  cur_step;
    logic            last_tok;
    logic            t_op;
    logic [OPW-1:0]  opc;
    logic signed [DW-1:0] t_val;
    logic [SIW-1:0]  idx_top, idx_nxt, wr_idx;
    logic signed [DW-1:0] top_v, nxt_v, op_a, op_b, res, wr_val;
    logic [DPW-1:0]  new_dep;
    logic            push_ovf, pop_unf;

    assign first    = (state == RECV) && !in_valid;
    assign eval_go  = (state == EVAL) || (first && !tok_ovf);
    assign cur_ptr  = first ? (mode_q ? '0 : PW'(cnt - CNW'(1))) : ptr;
    assign cur_dep  = first ? '0 : dep;
    assign cur_step = first ? '0 : step;
    assign last_tok = (cur_step == cnt - CNW'(1));

    assign t_op  = tok_op[cur_ptr];
    assign opc   = tok_val[cur_ptr];
    assign t_val = {{(DW-OPW){1'b0}}, tok_val[cur_ptr]};

    // Indices wrap harmlessly when depth < 2; those reads are never used.
    assign idx_top = SIW'(cur_dep - DPW'(1));
    assign idx_nxt = SIW'(cur_dep - DPW'(2));
    assign top_v   = stk[idx_top];
    assign nxt_v   = stk[idx_nxt];

    // Prefix: first pop is A. Postfix: first pop is B.
    assign op_a = mode_q ? nxt_v : top_v;
    assign op_b = mode_q ? top_v : nxt_v;

    assign push_ovf = !t_op && (cur_dep == DPW'(STK_DEPTH));
    assign pop_unf  = t_op && (cur_dep < DPW'(2));
    assign wr_idx   = t_op ? idx_nxt : SIW'(cur_dep);
    assign wr_val   = t_op ? res : t_val;
    assign new_dep  = t_op ? cur_dep - DPW'(1) : cur_dep + DPW'(1);

    // ---------------- ALU ----------------
    logic signed [DW-1:0] r_add, r_sub, r_mul, r_abs;

`ifdef PN_SAT_EN
    // Wide enough for the full product and for |sum| of two minimums.
    localparam int WW = 2*DW + 2;
    localparam logic signed [WW-1:0] SMAX = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [WW-1:0] SMIN = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [WW-1:0] a_w, b_w, sum_w, dif_w, prd_w, abs_w;

    function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] x);
        if (x > SMAX)      return SMAX[DW-1:0];
        else if (x < SMIN) return SMIN[DW-1:0];
        else               return x[DW-1:0];
    endfunction

    assign a_w   = {{(WW-DW){op_a[DW-1]}}, op_a};
    assign b_w   = {{(WW-DW){op_b[DW-1]}}, op_b};
    assign sum_w = a_w + b_w;
    assign dif_w = a_w - b_w;
    assign prd_w = a_w * b_w;
    assign abs_w = sum_w[WW-1] ? -sum_w : sum_w;
    assign r_add = sat(sum_w);
    assign r_sub = sat(dif_w);
    assign r_mul = sat(prd_w);
    assign r_abs = sat(abs_w);
`else
    // Low DW bits of the 2*DW product equal the DW-bit product.
    assign r_add = op_a + op_b;
    assign r_sub = op_a - op_b;
    assign r_mul = op_a * op_b;
    assign r_abs = r_add[DW-1] ? -r_add : r_add;
`endif

    always_comb begin
        res = '0;
        case (opc)
            OPW'(0): res = r_add;
            OPW'(1): res = r_sub;
            OPW'(2): res = r_mul;
            OPW'(3): res = r_abs;
            OPW'(4): res = (op_a < op_b) ? op_a : op_b;
            OPW'(5): res = (op_a > op_b) ? op_a : op_b;
            default: res = '0;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            step      <= '0;
            ptr       <= '0;
            dep       <= '0;
            mode_q    <= 1'b0;
            tok_ovf   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            err       <= '0;
            for (int i = 0; i < STK_DEPTH; i++) stk[i] <= '0;
        end else if (eval_go) begin
            if (push_ovf) begin
                state     <= DONE;
                out_valid <= 1'b1;
                out       <= '0;
                err       <= 2'd2;
            end else if (pop_unf) begin
                state     <= DONE;
                out_valid <= 1'b1;
                out       <= '0;
                err       <= 2'd1;
            end else begin
                stk[wr_idx] <= wr_val;
                dep         <= new_dep;
                if (last_tok) begin
                    // With a final depth of 1 the word just written is stack[0].
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out       <= (new_dep == DPW'(1)) ? wr_val : '0;
                    err       <= (new_dep == DPW'(1)) ? 2'd0 : 2'd2;
                end else begin
                    state <= EVAL;
                    ptr   <= mode_q ? cur_ptr + PW'(1) : cur_ptr - PW'(1);
                    step  <= cur_step + CNW'(1);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q  <= mode;
                        cnt     <= CNW'(1);
                        tok_ovf <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        if (cnt == CNW'(MAX_TOK)) tok_ovf <= 1'b1;
                        else                      cnt     <= cnt + CNW'(1);
                    end else begin
                        // Only reached with tok_ovf set; the normal case is eval_go.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= '0;
                        err       <= 2'd3;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    out       <= '0;
                    err       <= '0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
